// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the t0 packing sequencer state type.
// Also provides the t0 coefficient-to-13-bit conversion helper.
package dilithium_pkg;

   localparam int N             = 256;
   localparam int D             = 13;
   localparam int T0_OFFSET     = 4096;
   localparam int GROUP_COEFFS  = 8;
   localparam int GROUP_BYTES   = 13;
   localparam int POLYT0_BYTES  = 416;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EMIT    = 2'd2,
      ST_DONE    = 2'd3
   } polyt0_state_t;

   // 4096 - c computed at 32 bits, keeping only the low D bits.
   function automatic logic [D-1:0] t0_to_t(input logic signed [31:0] c);
      return D'(32'(T0_OFFSET) - $unsigned(c));
   endfunction

endpackage

// File: rtl/polyt0_group_pack.sv
// Combinational packer: eight 13-bit values into one 104-bit group word,
// value k occupying bits 13k+12:13k.
module polyt0_group_pack
   import dilithium_pkg::*;
(
   input  logic [D-1:0]                i_vals [GROUP_COEFFS],
   output logic [D*GROUP_COEFFS-1:0]   o_word
);

   always_comb begin
      o_word = '0;
      for (int k = 0; k < GROUP_COEFFS; k++) begin
         o_word[D*k +: D] = i_vals[k];
      end
   end

endmodule

// File: rtl/polyt0_pack_seq.sv
// Streaming Dilithium t0 packer: 256 coefficients in, 416 bytes out, one
// 104-bit group at a time. Optional range flag: POLYT0_RANGE_CHECK_EN.
module polyt0_pack_seq
   import dilithium_pkg::*;
#(
   parameter int COEFF_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   input  logic                       coef_valid,
   output logic                       coef_ready,
   input  logic signed [COEFF_W-1:0]  coef_data,
   output logic                       byte_valid,
   input  logic                       byte_ready,
   output logic [7:0]                 byte_data,
   output logic                       byte_last,
   output logic                       range_err
);

   localparam int WORD_W = D * GROUP_COEFFS;

   polyt0_state_t       r_state;
   polyt0_state_t       w_state_nxt;
   logic [4:0]          r_grp;
   logic [2:0]          r_cidx;
   logic [3:0]          r_bidx;
   logic [D-1:0]        r_t [GROUP_COEFFS-1];
   logic [WORD_W-1:0]   r_word;

   logic                w_coef_hs;
   logic                w_byte_hs;
   logic                w_start_acc;
   logic                w_grp_full;
   logic                w_grp_sent;
   logic [D-1:0]        w_t_in;
   logic [D-1:0]        w_vals [GROUP_COEFFS];
   logic [WORD_W-1:0]   w_word;
   logic [7:0]          w_byte;

   assign coef_ready  = (r_state == ST_COLLECT);
   assign byte_valid  = (r_state == ST_EMIT);
   assign busy        = (r_state != ST_IDLE);
   assign done        = (r_state == ST_DONE);
   assign w_coef_hs   = coef_valid && coef_ready;
   assign w_byte_hs   = byte_valid && byte_ready;
   assign w_start_acc = (r_state == ST_IDLE) && start;
   assign w_grp_full  = w_coef_hs && (r_cidx == 3'(GROUP_COEFFS - 1));
   assign w_grp_sent  = w_byte_hs && (r_bidx == 4'(GROUP_BYTES - 1));
   assign w_t_in      = t0_to_t(32'(coef_data));

   // The 8th value of a group goes straight from the port into the packer.
   always_comb begin
      for (int k = 0; k < GROUP_COEFFS - 1; k++) begin
         w_vals[k] = r_t[k];
      end
      w_vals[GROUP_COEFFS-1] = w_t_in;
   end

   polyt0_group_pack u_group_pack (
      .i_vals (w_vals),
      .o_word (w_word)
   );

   always_comb begin
      w_byte = '0;
      for (int j = 0; j < GROUP_BYTES; j++) begin
         if (r_bidx == 4'(j)) begin
            w_byte = r_word[8*j +: 8];
         end
      end
   end

   assign byte_data = byte_valid ? w_byte : 8'h00;
   assign byte_last = byte_valid && (r_grp == 5'd31) && (r_bidx == 4'(GROUP_BYTES - 1));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (start) w_state_nxt = ST_COLLECT;
         ST_COLLECT: if (w_grp_full) w_state_nxt = ST_EMIT;
         ST_EMIT: begin
            if (w_grp_sent) begin
               w_state_nxt = (r_grp != 5'd31) ? ST_COLLECT : ST_DONE;
            end
         end
         ST_DONE:    w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grp  <= '0;
         r_cidx <= '0;
         r_bidx <= '0;
      end else if (w_start_acc) begin
         r_grp  <= '0;
         r_cidx <= '0;
         r_bidx <= '0;
      end else begin
         if (w_coef_hs) r_cidx <= r_cidx + 3'd1;
         if (w_byte_hs) begin
            r_bidx <= w_grp_sent ? 4'd0 : r_bidx + 4'd1;
            if (w_grp_sent) r_grp <= r_grp + 5'd1;
         end
      end
   end

   // Shift register: after 7 handshakes, r_t[k] holds the k-th value of the group.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < GROUP_COEFFS - 1; k++) r_t[k] <= '0;
         r_word <= '0;
      end else begin
         if (w_coef_hs) begin
            for (int k = 0; k < GROUP_COEFFS - 2; k++) r_t[k] <= r_t[k+1];
            r_t[GROUP_COEFFS-2] <= w_t_in;
         end
         if (w_grp_full) r_word <= w_word;
      end
   end

`ifdef POLYT0_RANGE_CHECK_EN
   localparam logic signed [COEFF_W-1:0] C_LO = COEFF_W'(1 - T0_OFFSET);
   localparam logic signed [COEFF_W-1:0] C_HI = COEFF_W'(T0_OFFSET);

   logic r_range_err;
   logic w_out_of_range;

   assign w_out_of_range = (coef_data < C_LO) || (coef_data > C_HI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_range_err <= 1'b0;
      end else if (w_start_acc) begin
         r_range_err <= 1'b0;
      end else if (w_coef_hs && w_out_of_range) begin
         r_range_err <= 1'b1;
      end
   end

   assign range_err = r_range_err;
`else
   assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_polyt0_pack_seq.sv
// Bench for polyt0_pack_seq: directed and random polynomials checked against
// a bit-stream model of pack_t0 (honours POLYT0_RANGE_CHECK_EN).
module tb_polyt0_pack_seq;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              busy;
   logic              done;
   logic              coef_valid;
   logic              coef_ready;
   logic signed [31:0] coef_data;
   logic              byte_valid;
   logic              byte_ready;
   logic [7:0]        byte_data;
   logic              byte_last;
   logic              range_err;

   always #5 clk = ~clk;

   polyt0_pack_seq #(.COEFF_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .coef_valid (coef_valid),
      .coef_ready (coef_ready),
      .coef_data  (coef_data),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .byte_data  (byte_data),
      .byte_last  (byte_last),
      .range_err  (range_err)
   );

   int n_pass  = 0;
   int n_total = 0;

   logic signed [31:0] coefs     [256];
   logic [7:0]         exp_bytes [416];
   logic [7:0]         got_bytes [416];
   logic [7:0]         zero_grp  [13];

   int ci, bi, cyc, done_cyc, last_cyc;
   bit exp_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit in_range(input logic signed [31:0] c);
      return (c >= -32'sd4095) && (c <= 32'sd4096);
   endfunction

   // Reference: the polynomial is one little-endian bit stream of 13-bit t values.
   task automatic build_expected();
      for (int b = 0; b < 416; b++) begin
         logic [7:0] v;
         v = 8'h00;
         for (int k = 0; k < 8; k++) begin
            int p, i, s;
            logic [31:0] t;
            p = 8 * b + k;
            i = p / 13;
            s = p % 13;
            t = 32'd4096 - coefs[i];
            v[k] = t[s];
         end
         exp_bytes[b] = v;
      end
   endtask

   task automatic run_poly(input bit stall, input bit pulse_start, input int abort_at, input string tag);
      bit         prev_stall;
      bit         prev_coef_hs;
      logic [7:0] prev_data;
      build_expected();
      ci = 0; bi = 0; done_cyc = -1; last_cyc = -1; exp_err = 1'b0;
      prev_stall = 1'b0; prev_coef_hs = 1'b0; prev_data = 8'h00;
      @(negedge clk);
      start = 1'b1;
      cyc = 0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         cyc++;
         start = pulse_start && byte_valid && (bi == 50);
         if (prev_coef_hs || cyc == 1)
            check({tag, "_range_err"}, 32'(range_err), 32'(exp_err));
         if (prev_stall && byte_valid)
            check({tag, "_stall_stable"}, 32'(byte_data), 32'(prev_data));
         if (done) begin
            done_cyc = cyc;
            break;
         end
         coef_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         coef_data  = coefs[(ci < 256) ? ci : 0];
         byte_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         prev_coef_hs = coef_ready && coef_valid;
         if (prev_coef_hs) begin
`ifdef POLYT0_RANGE_CHECK_EN
            if (!in_range(coefs[ci])) exp_err = 1'b1;
`endif
            ci++;
         end
         if (byte_valid && byte_ready) begin
            if (bi < 416) begin
               got_bytes[bi] = byte_data;
               check($sformatf("%s_byte%0d", tag, bi), 32'(byte_data), 32'(exp_bytes[bi]));
               check($sformatf("%s_last%0d", tag, bi), 32'(byte_last), 32'(bi == 415));
            end
            if (bi == 415) last_cyc = cyc;
            bi++;
         end
         prev_stall = byte_valid && !byte_ready;
         prev_data  = byte_data;
         if (abort_at > 0 && ci == abort_at) break;
      end
      start      = 1'b0;
      coef_valid = 1'b0;
      byte_ready = 1'b0;
      if (abort_at == 0) begin
         check({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
         check({tag, "_coef_count"}, 32'(ci), 32'd256);
         check({tag, "_byte_count"}, 32'(bi), 32'd416);
         if (!stall) begin
            check({tag, "_done_cycle"}, 32'(done_cyc), 32'd673);
            check({tag, "_last_cycle"}, 32'(last_cyc), 32'd672);
         end
         @(negedge clk);
         check({tag, "_idle_busy"}, 32'(busy), 32'd0);
         check({tag, "_done_pulse"}, 32'(done), 32'd0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},       32'(busy),       32'd0);
      check({tag, "_done"},       32'(done),       32'd0);
      check({tag, "_coef_ready"}, 32'(coef_ready), 32'd0);
      check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
      check({tag, "_byte_data"},  32'(byte_data),  32'd0);
      check({tag, "_byte_last"},  32'(byte_last),  32'd0);
      check({tag, "_range_err"},  32'(range_err),  32'd0);
   endtask

   initial begin
      zero_grp = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h40, 8'h00, 8'h08,
                   8'h00, 8'h01, 8'h20, 8'h00, 8'h04, 8'h80};
      rst = 1'b1; start = 1'b0; coef_valid = 1'b0; coef_data = '0; byte_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      // All zero coefficients, no stalls.
      for (int i = 0; i < 256; i++) coefs[i] = 32'sd0;
      run_poly(1'b0, 1'b0, 0, "zero");
      for (int j = 0; j < 13; j++) begin
         check($sformatf("zero_grp0_b%0d", j), 32'(got_bytes[j]), 32'(zero_grp[j]));
         check($sformatf("zero_grp31_b%0d", j), 32'(got_bytes[403 + j]), 32'(zero_grp[j]));
      end

      // Boundary values of the t0 range.
      for (int i = 0; i < 256; i++) coefs[i] = 32'sd4096;
      run_poly(1'b0, 1'b0, 0, "c4096");
      check("c4096_b207", 32'(got_bytes[207]), 32'h00);
      for (int i = 0; i < 256; i++) coefs[i] = -32'sd4095;
      run_poly(1'b0, 1'b0, 0, "cm4095");
      check("cm4095_b207", 32'(got_bytes[207]), 32'hFF);

      // Random coefficients with random stalls on both ports.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 15) == 0) coefs[i] = $signed($urandom);
            else coefs[i] = $signed(32'($urandom_range(0, 8191))) - 32'sd4095;
         end
         run_poly(1'b1, 1'b0, 0, $sformatf("rand%0d", r));
      end

      // Reset after 100 coefficients, then a ramp.
      for (int i = 0; i < 256; i++) coefs[i] = $signed(32'($urandom_range(0, 8191))) - 32'sd4095;
      run_poly(1'b1, 1'b0, 100, "abort");
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 256; i++) coefs[i] = 32'(i) - 32'sd128;
      run_poly(1'b0, 1'b0, 0, "ramp");

      // Start pulsed during EMIT is ignored.
      for (int i = 0; i < 256; i++) coefs[i] = $signed(32'($urandom_range(0, 8191))) - 32'sd4095;
      run_poly(1'b0, 1'b1, 0, "pulse");

      // Out-of-range coefficient at index 5; flag must clear on the next start.
      for (int i = 0; i < 256; i++) coefs[i] = 32'sd0;
      coefs[5] = 32'sd4097;
      run_poly(1'b0, 1'b0, 0, "range");
`ifdef POLYT0_RANGE_CHECK_EN
      check("range_hold_after_done", 32'(range_err), 32'd1);
`else
      check("range_hold_after_done", 32'(range_err), 32'd0);
`endif
      coefs[5] = 32'sd0;
      run_poly(1'b0, 1'b0, 0, "range_clr");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/polyt0_pack_seq.md
# polyt0_pack_seq

Streaming sequencer for Dilithium t0 polynomial packing. It accepts 256 signed 32-bit coefficients one at a time over a valid/ready port. Each group of 8 is converted to 13-bit values and packed into 13 bytes, which are emitted over a byte valid/ready port: 416 bytes per polynomial. It sits between the t0 coefficient source (key generation, Power2Round output) and the public/secret-key byte serializer. It replaces the wide 8192-bit combinational pack path with a 104-bit group buffer.

## Interface
- COEFF_W, 32, coefficient input width (signed two's complement).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin one polynomial; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last byte handshake.
- coef_valid  in  1  coefficient offered.
- coef_ready  out  1  high only in COLLECT.
- coef_data  in  COEFF_W  signed coefficient.
- byte_valid  out  1  packed byte offered; high only in EMIT.
- byte_ready  in  1  downstream accepts byte.
- byte_data  out  8  packed byte.
- byte_last  out  1  high with byte_valid on byte 415 only.
- range_err  out  1  sticky out-of-range flag (see Configuration).

## Operation
- States: IDLE, COLLECT, EMIT, DONE.
- IDLE -> COLLECT on start.
- COLLECT -> EMIT after the 8th coefficient handshake of a group.
- EMIT -> COLLECT after byte 12 of the group when the group index is below 31. Otherwise EMIT -> DONE.
- DONE -> IDLE unconditionally.
- start while busy is ignored.
- Coefficient conversion: t = (4096 - coef_data) computed at 32 bits, truncated to 13 bits.
- The k-th coefficient of a group (k = 0..7) occupies bits 13k+12:13k of a 104-bit group word.
- Byte j of the group (j = 0..12) is group word bits 8j+7:8j. Its stream index is 13g + j, where g = 0..31 is the group counter.
- Counters: group counter 5 bits, coefficient-in-group counter 3 bits, byte-in-group counter 4 bits (0..12). All are cleared on start.
- Handshake: a transfer occurs when valid && ready on the same rising edge.
- byte_data and byte_last hold stable while byte_valid && !byte_ready.
- Coefficients are never accepted during EMIT, and bytes are never offered during COLLECT. There is no overlap between the two.

## Timing
- Reset values: busy=0, done=0, coef_ready=0, byte_valid=0, byte_data=0, byte_last=0, range_err=0. All counters and the group word are 0; state is IDLE.
- start high in cycle 0 puts the block in COLLECT in cycle 1.
- With no stalls, a group takes 21 cycles: 8 coefficient cycles followed by 13 byte cycles.
- Unstalled schedule: last byte in cycle 672, done=1 in cycle 673, IDLE with busy=0 in cycle 674.
- Stalls on either port extend the schedule cycle-for-cycle with no data loss.
- Asserting rst mid-operation returns the block to the reset state immediately and discards the partial group. No done pulse is generated.

## Configuration
- POLYT0_RANGE_CHECK_EN defined: a coefficient is accepted as in range when -4095 <= coef <= 4096.
  - Any accepted coefficient outside this range sets range_err.
  - range_err stays set until the next accepted start or reset.
  - Packing is unaffected: the truncated value is still emitted.
- POLYT0_RANGE_CHECK_EN undefined: range_err is tied to 0 and the comparator logic is absent.

## Structure
- Shared package (dilithium_pkg) holds:
  - N=256, D=13, T0_OFFSET=4096, GROUP_COEFFS=8, GROUP_BYTES=13, POLYT0_BYTES=416.
  - The state enum typedef.
- One sub-module, polyt0_group_pack: combinational, taking 8 values of 13 bits and producing a 104-bit group word. It is instantiated once, and its output is registered on the transition into EMIT.

## Test plan
- All coef=0, no stalls: each group emits 00 10 00 02 40 00 08 00 01 20 00 04 80, repeated 32 times. done in cycle 673, byte_last only on byte 415.
- All coef=4096: all 416 bytes are 0x00. All coef=-4095: all 416 bytes are 0xFF.
- Random byte_ready (50% duty) and random coef_valid gaps: the byte stream matches the software reference pack_t0 bit-exactly, and byte_data is stable during stalls.
- rst asserted after 100 coefficients: all outputs return to reset values. A subsequent start with the ramp input coef[i]=i-128 yields the correct 416-byte stream.
- start pulsed during EMIT: it is ignored, and the counts and stream are unchanged.
- With POLYT0_RANGE_CHECK_EN defined, coef=4097 at index 5: range_err rises after that handshake and holds until the next start; the packed t value is 0x1FFF. With the macro undefined, range_err stays 0.
